// File: rtl/computer_node.sv
// ============================================================================
// Module      : computer_node
// Description : Fabric processor node. Accepts one addressed transfer, buffers
//               its payload and replies to the sender with a 16-bit checksum.
//               Optional build macro NODE_RANGE_CHECK_EN adds node-id range checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module computer_node #(
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] node_id,
    input  logic [15:0] max_node,
    input  logic [31:0] control_rx_packet,
    output logic [31:0] control_tx_packet,
    input  logic [15:0] data_rx_node_id,
    input  logic [31:0] data_rx_packet,
    output logic [31:0] data_tx_packet
);

    localparam int                 c_PTR_W   = $clog2(RX_DEPTH + 1);
    localparam int                 c_IDX_W   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam logic [15:0]        c_DEPTH16 = 16'(RX_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_HDR = 3'd1,
        S_RX_DATA  = 3'd2,
        S_TX_CTRL  = 3'd3,
        S_TX_GAP   = 3'd4,
        S_TX_HDR   = 3'd5,
        S_TX_DATA  = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_hdr;
    logic [c_PTR_W-1:0] r_cnt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [15:0]        r_src;
    logic [15:0]        r_cksum;
    logic [15:0]        r_buf [RX_DEPTH];
    logic [31:0]        r_ctrl_tx;
    logic [31:0]        r_data_tx;

    logic [15:0]        w_ctrl_dest;
    logic [15:0]        w_ctrl_count;
    logic [15:0]        w_data_dest;
    logic [15:0]        w_data_payload;
    logic               w_ctrl_ok;
    logic               w_src_ok;
    logic               w_hdr_match;
    logic               w_word_valid;
    logic               w_word_ours;
    logic [c_PTR_W-1:0] w_ptr_inc;
    logic               w_last;
    logic               w_ctrl_accept;
    logic               w_hdr_accept;
    logic               w_store;
    logic               w_unused_ok;

    assign w_ctrl_dest    = control_rx_packet[31:16];
    assign w_ctrl_count   = control_rx_packet[15:0];
    assign w_data_dest    = data_rx_packet[31:16];
    assign w_data_payload = data_rx_packet[15:0];
    assign w_hdr_match    = (data_rx_packet == r_hdr);
    assign w_word_valid   = (data_rx_packet != 32'h0);
    assign w_word_ours    = (w_data_dest == node_id);
    assign w_ptr_inc      = r_ptr + c_PTR_ONE;
    assign w_last         = (w_ptr_inc == r_cnt);

`ifdef NODE_RANGE_CHECK_EN
    assign w_ctrl_ok   = (w_ctrl_dest == node_id) && (w_ctrl_count != 16'h0) &&
                         (w_ctrl_count <= c_DEPTH16) && (w_ctrl_dest < max_node);
    assign w_src_ok    = (data_rx_node_id < max_node) && (data_rx_node_id != node_id);
    assign w_unused_ok = ^r_buf[r_ptr[c_IDX_W-1:0]];
`else
    assign w_ctrl_ok   = (w_ctrl_dest == node_id) && (w_ctrl_count != 16'h0) &&
                         (w_ctrl_count <= c_DEPTH16);
    assign w_src_ok    = 1'b1;
    assign w_unused_ok = ^{max_node, r_buf[r_ptr[c_IDX_W-1:0]]};
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_ctrl_accept = 1'b0;
        w_hdr_accept  = 1'b0;
        w_store       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ctrl_ok) begin
                    w_ctrl_accept = 1'b1;
                    w_state_nxt   = S_WAIT_HDR;
                end
            end
            S_WAIT_HDR: begin
                if (w_hdr_match) begin
                    if (w_src_ok) begin
                        w_hdr_accept = 1'b1;
                        w_state_nxt  = S_RX_DATA;
                    end else begin
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            S_RX_DATA: begin
                // A stray word for another node means the stream is corrupt: drop it silently.
                if (w_word_valid) begin
                    if (!w_word_ours) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_store = 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_TX_CTRL;
                        end
                    end
                end
            end
            S_TX_CTRL: w_state_nxt = S_TX_GAP;
            S_TX_GAP:  w_state_nxt = S_TX_HDR;
            S_TX_HDR:  w_state_nxt = S_TX_DATA;
            S_TX_DATA: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hdr     <= 32'h0;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_src     <= 16'h0;
            r_cksum   <= 16'h0;
            r_ctrl_tx <= 32'h0;
            r_data_tx <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ctrl_accept) begin
                r_hdr <= control_rx_packet;
                r_cnt <= w_ctrl_count[c_PTR_W-1:0];
            end
            if (w_hdr_accept) begin
                r_src   <= data_rx_node_id;
                r_cksum <= 16'h0;
                r_ptr   <= '0;
            end
            if (w_store) begin
                r_cksum <= r_cksum + w_data_payload;
                r_ptr   <= w_ptr_inc;
            end
            // Outputs are decoded from the next state so each reply word appears in its own state cycle.
            r_ctrl_tx <= (w_state_nxt == S_TX_CTRL) ? {r_src, 16'd1} : 32'h0;
            if (w_state_nxt == S_TX_HDR) begin
                r_data_tx <= {r_src, 16'd1};
            end else if (w_state_nxt == S_TX_DATA) begin
                r_data_tx <= {r_src, r_cksum};
            end else begin
                r_data_tx <= 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[r_ptr[c_IDX_W-1:0]] <= w_data_payload;
        end
    end

    assign control_tx_packet = r_ctrl_tx;
    assign data_tx_packet    = r_data_tx;

endmodule

`default_nettype wire

// File: tb/tb_computer_node.sv
// ============================================================================
// Module      : tb_computer_node
// Description : Randomized transfer-level bench for computer_node with a
//               checksum/reply scoreboard. Honours NODE_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_computer_node;

    localparam int RX_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] node_id;
    logic [15:0] max_node;
    logic [31:0] control_rx_packet;
    logic [31:0] control_tx_packet;
    logic [15:0] data_rx_node_id;
    logic [31:0] data_rx_packet;
    logic [31:0] data_tx_packet;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q_ctrl[$];
    logic [31:0] q_data[$];

    always #5 clk = ~clk;

    computer_node #(.RX_DEPTH(RX_DEPTH)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .node_id           (node_id),
        .max_node          (max_node),
        .control_rx_packet (control_rx_packet),
        .control_tx_packet (control_tx_packet),
        .data_rx_node_id   (data_rx_node_id),
        .data_rx_packet    (data_rx_packet),
        .data_tx_packet    (data_tx_packet)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock, then compare both outputs with the next scoreboard entry.
    task automatic step(input string tag);
        logic [31:0] ec;
        logic [31:0] ed;
        @(posedge clk);
        #1;
        ec = 32'h0;
        ed = 32'h0;
        if (q_ctrl.size() > 0) ec = q_ctrl.pop_front();
        if (q_data.size() > 0) ed = q_data.pop_front();
        chk({tag, "/ctrl_tx"}, control_tx_packet, ec);
        chk({tag, "/data_tx"}, data_tx_packet, ed);
    endtask

    // pmode: 0 random payload, 1 all 16'hFFFF, 2 16'h000A + index
    task automatic run_xfer(input logic [15:0] dest, input logic [15:0] cnt, input logic [15:0] src,
                            input int pmode, input int bad_pos, input int rst_pos, input string tag);
        logic [31:0] hdr;
        logic [31:0] noise;
        logic [15:0] p;
        bit          ctrl_ok;
        bit          live;
        int          n;
        int          sum;
        hdr     = {dest, cnt};
        sum     = 0;
        ctrl_ok = (dest == node_id) && (cnt >= 16'd1) && (cnt <= 16'(RX_DEPTH));
`ifdef NODE_RANGE_CHECK_EN
        ctrl_ok = ctrl_ok && (dest < max_node);
        live    = ctrl_ok && (src < max_node) && (src != node_id);
`else
        live    = ctrl_ok;
`endif
        control_rx_packet = hdr;
        data_rx_packet    = 32'h0;
        step({tag, "/ctl"});
        control_rx_packet = 32'h0;
        repeat ($urandom_range(0, 3)) begin
            noise = $urandom;
            if (noise == hdr) noise = noise ^ 32'h1;
            data_rx_packet  = noise;
            data_rx_node_id = 16'($urandom);
            step({tag, "/gap"});
        end
        data_rx_packet  = hdr;
        data_rx_node_id = src;
        if (ctrl_ok) control_rx_packet = {node_id, 16'd2};
        step({tag, "/hdr"});
        control_rx_packet = 32'h0;
        n = (cnt > 16'd20) ? 20 : int'(cnt);
        for (int i = 0; i < n; i++) begin
            if (i == rst_pos) begin
                rst            = 1'b1;
                data_rx_packet = 32'h0;
                step({tag, "/rst"});
                rst  = 1'b0;
                live = 1'b0;
            end
            repeat ($urandom_range(0, 1)) begin
                data_rx_packet = 32'h0;
                step({tag, "/idle"});
            end
            case (pmode)
                1:       p = 16'hFFFF;
                2:       p = 16'h000A + 16'(i);
                default: p = 16'($urandom);
            endcase
            if (i == bad_pos) begin
                data_rx_packet = {16'h0002, p};
                live           = 1'b0;
            end else begin
                data_rx_packet = {node_id, p};
                sum            = sum + int'(p);
                if (live && i == n - 1) begin
                    q_ctrl.push_back({src, 16'd1});
                    q_data.push_back(32'h0);
                    q_ctrl.push_back(32'h0);
                    q_data.push_back(32'h0);
                    q_ctrl.push_back(32'h0);
                    q_data.push_back({src, 16'd1});
                    q_ctrl.push_back(32'h0);
                    q_data.push_back({src, 16'(sum)});
                end
            end
            if (live && ($urandom_range(0, 3) == 0)) control_rx_packet = {node_id, 16'd1};
            data_rx_node_id = 16'($urandom);
            step({tag, "/word"});
            control_rx_packet = 32'h0;
        end
        data_rx_packet = 32'h0;
        repeat (6) step({tag, "/drain"});
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] c;
        int          r;
        rst               = 1'b1;
        node_id           = 16'd1;
        max_node          = 16'd4;
        control_rx_packet = 32'h0;
        data_rx_node_id   = 16'd3;
        data_rx_packet    = 32'h0;
        step("reset");
        step("reset");
        rst = 1'b0;
        step("post_reset");

        run_xfer(16'd1, 16'd4, 16'd3, 2, -1, -1, "t1");
        run_xfer(16'd2, 16'd4, 16'd3, 2, -1, -1, "t2_wrong_dest");
        run_xfer(16'd1, 16'd0, 16'd3, 0, -1, -1, "t3_cnt0");
        run_xfer(16'd1, 16'(RX_DEPTH + 1), 16'd3, 0, -1, -1, "t3_cnt_over");
        run_xfer(16'd1, 16'(RX_DEPTH), 16'd3, 1, -1, -1, "t3_wrap");
        run_xfer(16'd1, 16'd4, 16'd3, 2, -1, 2, "t4_rst");
        run_xfer(16'd1, 16'd4, 16'd3, 2, -1, -1, "t4_after");
        run_xfer(16'd1, 16'd4, 16'd3, 2, 1, -1, "t5_bad");
        run_xfer(16'd1, 16'd4, 16'd3, 2, -1, -1, "t5_after");
`ifdef NODE_RANGE_CHECK_EN
        run_xfer(16'd1, 16'd4, 16'd5, 2, -1, -1, "t6_src_range");
        run_xfer(16'd1, 16'd4, 16'd1, 2, -1, -1, "t6_src_self");
        run_xfer(16'd1, 16'd4, 16'd2, 2, -1, -1, "t6_src_ok");
`endif

        for (int k = 0; k < 40; k++) begin
            d = ($urandom_range(0, 1) == 1) ? node_id : 16'($urandom_range(0, 5));
            r = $urandom_range(0, 9);
            if (r == 0)      c = 16'd0;
            else if (r == 1) c = 16'(RX_DEPTH + 1);
            else if (r == 2) c = 16'(RX_DEPTH);
            else             c = 16'($urandom_range(1, RX_DEPTH));
            run_xfer(d, c, 16'($urandom_range(0, 5)), $urandom_range(0, 1),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1,
                     ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1,
                     "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
